clint_axi_nhart: RTL and testbench

Parametrised core-local interruptor with an AXI4 slave port, successor to the two-hart software-interrupt-only CLINT. Provides per-hart machine and supervisor software-interrupt bits, a 64-bit free-running `mtime` with a programmable prescaler, and per-hart 64-bit `mtimecmp` comparators driving machine timer interrupts. It sits on the peripheral AXI interconnect and feeds the interrupt inputs of every hart in the cluster.

---
 rtl/clint_axi_nhart_if.sv | 42 ++++
 rtl/clint_axi_nhart.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_clint_axi_nhart.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_axi_nhart_if.sv
// clint_axi_nhart_if
// AXI4 subset bus (single-beat, no IDs) used to reach the core-local
// interruptor. The master modport is the interconnect side and the slave
// modport is the CLINT side.
//   aw*: write address  w*: write data  b*: write response
//   ar*: read address   r*: read data
interface clint_axi_nhart_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wlast, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wlast, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arvalid, output arready,
      output rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/clint_axi_nhart.sv
// clint_axi_nhart
// Core-local interruptor for NUM_HARTS harts behind an AXI4 slave port.
// Holds per-hart MSIP/SSIP software-interrupt bits, a 64-bit mtime advanced
// once every TIMEBASE_DIV clocks, and per-hart 64-bit mtimecmp comparators.
// Ports:
//   aclk, areset  clock and asynchronous active-high reset
//   bus           AXI4 slave (single beat; wlast ignored, rlast = rvalid)
//   ipi_m_o       machine software interrupt per hart (from MSIP bit 0)
//   ipi_s_o       supervisor software interrupt per hart (from SSIP bit 0)
//   timer_irq_o   registered mtime >= mtimecmp[h] per hart
module clint_axi_nhart #(
   parameter int unsigned NUM_HARTS    = 2,
   parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
   parameter int unsigned TIMEBASE_DIV = 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   clint_axi_nhart_if.slave     bus,
   output logic [NUM_HARTS-1:0] ipi_m_o,
   output logic [NUM_HARTS-1:0] ipi_s_o,
   output logic [NUM_HARTS-1:0] timer_irq_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;
   typedef enum logic [2:0] {K_NONE, K_MSIP, K_SSIP, K_MTCMP, K_MTIME} kind_t;

   typedef struct packed {
      logic [1:0] resp;
      kind_t      kind;
      logic [4:0] hart;
      logic       hi;     // upper 32-bit half of a 64-bit register
   } dec_t;

   // Address decode shared by the read and write paths. Only the upper 16
   // bits are compared against the base since the block is 64 KiB aligned.
   function automatic dec_t decode(input logic [31:0] addr);
      dec_t d;
      d.resp = RESP_DECERR;
      d.kind = K_NONE;
      d.hart = 5'd0;
      d.hi   = 1'b0;
      if (addr[31:16] != BASE_ADDR[31:16]) begin
         d.resp = RESP_DECERR;
      end else if (addr[1:0] != 2'b00) begin
         d.resp = RESP_SLVERR;
      end else begin
         case (addr[15:14])
            2'b00: begin
               if ({20'd0, addr[13:2]} < NUM_HARTS) begin
                  d.resp = RESP_OKAY;
                  d.kind = K_MSIP;
                  d.hart = addr[6:2];
               end else begin
                  d.resp = RESP_DECERR;
               end
            end
            2'b01: begin
               if ({21'd0, addr[13:3]} < NUM_HARTS) begin
                  d.resp = RESP_OKAY;
                  d.kind = K_MTCMP;
                  d.hart = addr[7:3];
                  d.hi   = addr[2];
               end else begin
                  d.resp = RESP_DECERR;
               end
            end
            2'b10: begin
               // 0xBFF8 / 0xBFFC are the only live words in this quarter
               if (addr[13:3] == 11'h7FF) begin
                  d.resp = RESP_OKAY;
                  d.kind = K_MTIME;
                  d.hi   = addr[2];
               end else begin
                  d.resp = RESP_DECERR;
               end
            end
            default: begin
               if ({20'd0, addr[13:2]} < NUM_HARTS) begin
                  d.resp = RESP_OKAY;
                  d.kind = K_SSIP;
                  d.hart = addr[6:2];
               end else begin
                  d.resp = RESP_DECERR;
               end
            end
         endcase
      end
      return d;
   endfunction

   // register state
   logic [NUM_HARTS-1:0] msip_r;
   logic [NUM_HARTS-1:0] ssip_r;
   logic [63:0]          mtimecmp_r [NUM_HARTS];
   logic [63:0]          mtime_r;
   logic [31:0]          presc_r;
   logic [NUM_HARTS-1:0] timer_irq_r;
   logic                 tick_s;

   // write path
   wstate_t     w_state_r, w_state_nxt_s;
   logic        aw_held_r, aw_held_nxt_s;
   logic        w_held_r, w_held_nxt_s;
   logic        awready_r, wready_r;
   logic [31:0] waddr_r, wdata_r;
   logic        bvalid_r;
   logic [1:0]  bresp_r;
   dec_t        wdec_s;
   logic        wcommit_s;

   // read path
   rstate_t     r_state_r, r_state_nxt_s;
   logic        arready_r;
   logic        ar_hs_s;
   logic [31:0] rdata_r, rd_mux_s;
   logic [1:0]  rresp_r;
   logic        rvalid_r;
   dec_t        rdec_s;

   logic        unused_wlast_s;

   assign unused_wlast_s = bus.wlast;
   assign wdec_s    = decode(waddr_r);
   assign wcommit_s = (w_state_r == W_COMMIT) && (wdec_s.resp == RESP_OKAY);
   assign rdec_s    = decode(bus.araddr);
   assign ar_hs_s   = (r_state_r == R_IDLE) && bus.arvalid && arready_r;
   assign tick_s    = (presc_r == 32'(TIMEBASE_DIV - 1));

   assign bus.awready = awready_r;
   assign bus.wready  = wready_r;
   assign bus.bvalid  = bvalid_r;
   assign bus.bresp   = bresp_r;
   assign bus.arready = arready_r;
   assign bus.rvalid  = rvalid_r;
   assign bus.rlast   = rvalid_r;
   assign bus.rdata   = rdata_r;
   assign bus.rresp   = rresp_r;

   assign ipi_m_o     = msip_r;
   assign ipi_s_o     = ssip_r;
   assign timer_irq_o = timer_irq_r;

   // Write FSM next state: AW and W are latched independently in W_IDLE and
   // the commit starts only on the cycle after both are held.
   always_comb begin
      w_state_nxt_s = w_state_r;
      aw_held_nxt_s = aw_held_r;
      w_held_nxt_s  = w_held_r;
      case (w_state_r)
         W_IDLE: begin
            aw_held_nxt_s = aw_held_r | (bus.awvalid & awready_r);
            w_held_nxt_s  = w_held_r | (bus.wvalid & wready_r);
            if (aw_held_r && w_held_r) begin
               w_state_nxt_s = W_COMMIT;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_COMMIT: begin
            w_state_nxt_s = W_RESP;
            aw_held_nxt_s = 1'b0;
            w_held_nxt_s  = 1'b0;
         end
         W_RESP: begin
            if (bus.bready) begin
               w_state_nxt_s = W_IDLE;
            end else begin
               w_state_nxt_s = W_RESP;
            end
         end
         default: begin
            w_state_nxt_s = W_IDLE;
            aw_held_nxt_s = 1'b0;
            w_held_nxt_s  = 1'b0;
         end
      endcase
   end

   // Write FSM state, channel capture, ready flags and the B channel.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_r <= W_IDLE;
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         waddr_r   <= 32'd0;
         wdata_r   <= 32'd0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
      end else begin
         w_state_r <= w_state_nxt_s;
         aw_held_r <= aw_held_nxt_s;
         w_held_r  <= w_held_nxt_s;
         awready_r <= (w_state_nxt_s == W_IDLE) && !aw_held_nxt_s;
         wready_r  <= (w_state_nxt_s == W_IDLE) && !w_held_nxt_s;
         if (bus.awvalid && awready_r) begin
            waddr_r <= bus.awaddr;
         end
         if (bus.wvalid && wready_r) begin
            wdata_r <= bus.wdata;
         end
         if (w_state_r == W_COMMIT) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wdec_s.resp;
         end else if ((w_state_r == W_RESP) && bus.bready) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Timebase, register file updates and registered timer compare.
   // An mtime write replaces the tick on the same edge; the prescaler keeps
   // running so the tick phase is not disturbed by software writes.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         msip_r      <= '0;
         ssip_r      <= '0;
         mtime_r     <= 64'd0;
         presc_r     <= 32'd0;
         timer_irq_r <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            mtimecmp_r[h] <= {64{1'b1}};
         end
      end else begin
         presc_r <= tick_s ? 32'd0 : presc_r + 32'd1;
         if (wcommit_s && (wdec_s.kind == K_MTIME)) begin
            if (wdec_s.hi) begin
               mtime_r[63:32] <= wdata_r;
            end else begin
               mtime_r[31:0] <= wdata_r;
            end
         end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
         end
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (wcommit_s && (wdec_s.hart == 5'(h))) begin
               case (wdec_s.kind)
                  K_MSIP:  msip_r[h] <= wdata_r[0];
                  K_SSIP:  ssip_r[h] <= wdata_r[0];
                  K_MTCMP: begin
                     if (wdec_s.hi) begin
                        mtimecmp_r[h][63:32] <= wdata_r;
                     end else begin
                        mtimecmp_r[h][31:0] <= wdata_r;
                     end
                  end
                  default: ;
               endcase
            end
            timer_irq_r[h] <= (mtime_r >= mtimecmp_r[h]);
         end
      end
   end

   // Read data mux; unmapped and misaligned addresses read as zero.
   always_comb begin
      rd_mux_s = 32'd0;
      case (rdec_s.kind)
         K_MTIME: begin
            if (rdec_s.hi) begin
               rd_mux_s = mtime_r[63:32];
            end else begin
               rd_mux_s = mtime_r[31:0];
            end
         end
         K_MSIP, K_SSIP, K_MTCMP: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (rdec_s.hart == 5'(h)) begin
                  case (rdec_s.kind)
                     K_MSIP:  rd_mux_s = {31'd0, msip_r[h]};
                     K_SSIP:  rd_mux_s = {31'd0, ssip_r[h]};
                     default: rd_mux_s = rdec_s.hi ? mtimecmp_r[h][63:32]
                                                   : mtimecmp_r[h][31:0];
                  endcase
               end else begin
                  rd_mux_s = rd_mux_s;
               end
            end
         end
         default: rd_mux_s = 32'd0;
      endcase
   end

   // Read FSM next state.
   always_comb begin
      r_state_nxt_s = r_state_r;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_state_nxt_s = R_DATA;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (bus.rready) begin
               r_state_nxt_s = R_IDLE;
            end else begin
               r_state_nxt_s = R_DATA;
            end
         end
         default: r_state_nxt_s = R_IDLE;
      endcase
   end

   // Read FSM state and R channel; data is sampled from pre-edge register
   // state so a same-edge commit is not visible to this read.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rdata_r   <= 32'd0;
         rresp_r   <= RESP_OKAY;
         rvalid_r  <= 1'b0;
      end else begin
         r_state_r <= r_state_nxt_s;
         arready_r <= (r_state_nxt_s == R_IDLE);
         if (ar_hs_s) begin
            rdata_r  <= rd_mux_s;
            rresp_r  <= rdec_s.resp;
            rvalid_r <= 1'b1;
         end else if ((r_state_r == R_DATA) && bus.rready) begin
            rvalid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clint_axi_nhart.sv
// tb_clint_axi_nhart
// Directed bench: a NUM_HARTS=2 / TIMEBASE_DIV=1 instance carries most
// scenarios; a TIMEBASE_DIV=4 instance checks the prescaler after reset.
module tb_clint_axi_nhart;

   logic aclk = 1'b0;
   logic areset;
   int   total = 0;
   int   bad = 0;

   always #5 aclk = ~aclk;

   clint_axi_nhart_if bus ();
   clint_axi_nhart_if bus4 ();

   logic [1:0] ipi_m, ipi_s, tirq;
   logic [1:0] ipi_m4, ipi_s4, tirq4;

   clint_axi_nhart #(.NUM_HARTS(2), .BASE_ADDR(32'h0200_0000), .TIMEBASE_DIV(1)) dut (
      .aclk(aclk), .areset(areset), .bus(bus),
      .ipi_m_o(ipi_m), .ipi_s_o(ipi_s), .timer_irq_o(tirq));

   clint_axi_nhart #(.NUM_HARTS(2), .BASE_ADDR(32'h0200_0000), .TIMEBASE_DIV(4)) dut4 (
      .aclk(aclk), .areset(areset), .bus(bus4),
      .ipi_m_o(ipi_m4), .ipi_s_o(ipi_s4), .timer_irq_o(tirq4));

   // Single write on the main instance; lat counts cycles from the edge
   // completing the later of AW/W to the first cycle bvalid is seen.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic [1:0] resp, output int lat);
      int   n;
      logic aw_done, w_done;
      bus.awaddr = addr; bus.wdata = data; bus.wlast = 1'b1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 20) begin
         if (bus.awvalid && bus.awready) aw_done = 1'b1;
         if (bus.wvalid && bus.wready) w_done = 1'b1;
         @(negedge aclk);
         if (aw_done) bus.awvalid = 1'b0;
         if (w_done) bus.wvalid = 1'b0;
         n++;
      end
      lat = 0;
      while (!bus.bvalid && lat < 20) begin
         @(negedge aclk);
         lat++;
      end
      if (lat >= 20 || n >= 20) begin
         total++; bad++;
         $display("FAIL wr_timeout addr=%h: got no response want bvalid", addr);
      end
      resp = bus.bresp;
      @(negedge aclk);
   endtask

   // Single read on the main instance; lat counts cycles from the AR edge.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int n;
      bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      n = 0;
      while (!bus.arready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      bus.arvalid = 1'b0;
      lat = 1;
      while (!bus.rvalid && lat < 20) begin
         @(negedge aclk);
         lat++;
      end
      if (lat >= 20 || n >= 20) begin
         total++; bad++;
         $display("FAIL rd_timeout addr=%h: got no response want rvalid", addr);
      end
      data = bus.rdata; resp = bus.rresp;
      @(negedge aclk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      repeat (3) @(negedge aclk);
      total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin bad++;
         $display("FAIL rst_ready: got %b want 000", {bus.awready, bus.wready, bus.arready}); end
      total++; if ({bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp} !== 7'd0) begin bad++;
         $display("FAIL rst_resp: got %b want 0", {bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp}); end
      total++; if (bus.rdata !== 32'd0) begin bad++;
         $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
      total++; if ({ipi_m, ipi_s, tirq} !== 6'd0) begin bad++;
         $display("FAIL rst_irq: got %b want 0", {ipi_m, ipi_s, tirq}); end
      areset = 1'b0;                 // released at N0
      @(negedge aclk);               // N1
      total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin bad++;
         $display("FAIL rel_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
      repeat (19) @(negedge aclk);   // N20: mtime(div4) = 5 after 20 edges
      bus4.araddr = 32'h0200_BFF8; bus4.arvalid = 1'b1; bus4.rready = 1'b1;
      @(negedge aclk);
      bus4.arvalid = 1'b0;
      total++; if (bus4.rvalid !== 1'b1 || bus4.rdata !== 32'h5) begin bad++;
         $display("FAIL presc_mtime: got v=%b d=%h want v=1 d=5", bus4.rvalid, bus4.rdata); end
      @(negedge aclk);
      bus4.rready = 1'b0;
      axi_read(32'h0200_4000, d, r, lat);
      total++; if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin bad++;
         $display("FAIL rst_mtimecmp: got %h/%b want ffffffff/00", d, r); end
      total++; if ({tirq, tirq4, ipi_m4, ipi_s4} !== 8'd0) begin bad++;
         $display("FAIL rst_noirq: got %b want 0", {tirq, tirq4, ipi_m4, ipi_s4}); end
   endtask

   task automatic test_msip_ssip();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h0200_0004, 32'h3, r, lat);
      total++; if (lat !== 2 || r !== 2'b00) begin bad++;
         $display("FAIL msip_wr: got lat=%0d resp=%b want 2/00", lat, r); end
      total++; if (ipi_m !== 2'b10) begin bad++;
         $display("FAIL msip_ipi: got %b want 10", ipi_m); end
      axi_read(32'h0200_0004, d, r, lat);
      total++; if (d !== 32'h1 || r !== 2'b00 || lat !== 1) begin bad++;
         $display("FAIL msip_rd: got %h/%b lat=%0d want 1/00 lat=1", d, r, lat); end
      axi_write(32'h0200_0004, 32'h0, r, lat);
      total++; if (ipi_m !== 2'b00) begin bad++;
         $display("FAIL msip_clr: got %b want 00", ipi_m); end
      axi_write(32'h0200_C000, 32'h1, r, lat);
      total++; if (ipi_s !== 2'b01 || ipi_m !== 2'b00) begin bad++;
         $display("FAIL ssip_ipi: got s=%b m=%b want 01/00", ipi_s, ipi_m); end
      axi_read(32'h0200_C000, d, r, lat);
      total++; if (d !== 32'h1 || r !== 2'b00) begin bad++;
         $display("FAIL ssip_rd: got %h/%b want 1/00", d, r); end
      axi_write(32'h0200_C000, 32'h0, r, lat);
      total++; if (ipi_s !== 2'b00) begin bad++;
         $display("FAIL ssip_clr: got %b want 00", ipi_s); end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] r;
      int         lat;
      bus.awaddr = 32'h0200_0000; bus.wdata = 32'h1; bus.bready = 1'b0;
      bus.wvalid = 1'b1;
      @(negedge aclk);
      bus.wvalid = 1'b0;
      total++; if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin bad++;
         $display("FAIL wfirst_ready: got w=%b aw=%b want 0/1", bus.wready, bus.awready); end
      repeat (2) @(negedge aclk);
      bus.awvalid = 1'b1;
      @(negedge aclk);
      bus.awvalid = 1'b0;
      @(negedge aclk);
      total++; if (bus.bvalid !== 1'b0) begin bad++;
         $display("FAIL wfirst_early: got bvalid=%b want 0", bus.bvalid); end
      @(negedge aclk);
      total++; if (bus.bvalid !== 1'b1 || ipi_m !== 2'b01) begin bad++;
         $display("FAIL wfirst_b: got bvalid=%b ipi=%b want 1/01", bus.bvalid, ipi_m); end
      bus.awaddr = 32'h0200_0004; bus.wdata = 32'h1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin bad++;
            $display("FAIL bstall_%0d: got %b want 10000", i, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
         @(negedge aclk);
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      total++; if (ipi_m !== 2'b01) begin bad++;
         $display("FAIL bstall_noacc: got %b want 01", ipi_m); end
      bus.bready = 1'b1;
      @(negedge aclk);
      total++; if (bus.bvalid !== 1'b0) begin bad++;
         $display("FAIL bstall_done: got bvalid=%b want 0", bus.bvalid); end
      axi_write(32'h0200_0000, 32'h0, r, lat);
   endtask

   task automatic test_timer();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h0200_4004, 32'h0, r, lat);
      axi_write(32'h0200_4000, 32'h40, r, lat);
      // mtime low = 0x30; the task returns one edge after the commit (0x31)
      axi_write(32'h0200_BFF8, 32'h30, r, lat);
      total++; if (tirq !== 2'b00) begin bad++;
         $display("FAIL tmr_low: got %b want 00", tirq); end
      repeat (15) @(negedge aclk);   // mtime just became 0x40
      total++; if (tirq[0] !== 1'b0) begin bad++;
         $display("FAIL tmr_pre: got %b want 0", tirq[0]); end
      @(negedge aclk);
      total++; if (tirq !== 2'b01) begin bad++;
         $display("FAIL tmr_rise: got %b want 01", tirq); end
      axi_write(32'h0200_4000, 32'hFFFF_0000, r, lat);
      total++; if (tirq !== 2'b00) begin bad++;
         $display("FAIL tmr_drop: got %b want 00", tirq); end
      axi_read(32'h0200_4000, d, r, lat);
      total++; if (d !== 32'hFFFF_0000) begin bad++;
         $display("FAIL tmr_cmp_rd: got %h want ffff0000", d); end
   endtask

   task automatic test_mtime_wrap();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h0200_BFFC, 32'hFFFF_FFFF, r, lat);
      axi_write(32'h0200_BFF8, 32'hFFFF_FFFE, r, lat);
      // reads sample mtime before edges commit+2, +4, +6
      axi_read(32'h0200_BFF8, d, r, lat);
      total++; if (d !== 32'hFFFF_FFFF) begin bad++;
         $display("FAIL wrap_lo1: got %h want ffffffff", d); end
      axi_read(32'h0200_BFFC, d, r, lat);
      total++; if (d !== 32'h0) begin bad++;
         $display("FAIL wrap_hi: got %h want 0", d); end
      axi_read(32'h0200_BFF8, d, r, lat);
      total++; if (d !== 32'h3) begin bad++;
         $display("FAIL wrap_lo2: got %h want 3", d); end
      // every edge ticks with div 1, so the write must drop its tick
      axi_write(32'h0200_BFF8, 32'h1000, r, lat);
      axi_read(32'h0200_BFF8, d, r, lat);
      total++; if (d !== 32'h1001) begin bad++;
         $display("FAIL tick_coll: got %h want 1001", d); end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_read(32'h0200_8000, d, r, lat);
      total++; if (d !== 32'h0 || r !== 2'b11) begin bad++;
         $display("FAIL dec_rd: got %h/%b want 0/11", d, r); end
      axi_write(32'h0200_8000, 32'h1, r, lat);
      total++; if (r !== 2'b11) begin bad++;
         $display("FAIL dec_wr: got %b want 11", r); end
      axi_write(32'h0200_0008, 32'h1, r, lat);
      total++; if (r !== 2'b11 || ipi_m !== 2'b00) begin bad++;
         $display("FAIL msip_oob: got %b ipi=%b want 11/00", r, ipi_m); end
      axi_read(32'h0200_4010, d, r, lat);
      total++; if (d !== 32'h0 || r !== 2'b11) begin bad++;
         $display("FAIL cmp_oob: got %h/%b want 0/11", d, r); end
      axi_write(32'h0200_0002, 32'h1, r, lat);
      total++; if (r !== 2'b10 || ipi_m !== 2'b00) begin bad++;
         $display("FAIL slv_wr: got %b ipi=%b want 10/00", r, ipi_m); end
      axi_read(32'h0200_0002, d, r, lat);
      total++; if (d !== 32'h0 || r !== 2'b10) begin bad++;
         $display("FAIL slv_rd: got %h/%b want 0/10", d, r); end
      axi_read(32'h0200_0000, d, r, lat);
      total++; if (d !== 32'h0 || r !== 2'b00) begin bad++;
         $display("FAIL err_nochg: got %h/%b want 0/00", d, r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h0200_0000, 32'h1, r, lat);
      bus.awaddr = 32'h0200_0004; bus.wdata = 32'h1; bus.bready = 1'b0;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge aclk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(negedge aclk);               // now in W_COMMIT
      areset = 1'b1;
      #1;
      total++; if ({bus.bvalid, bus.awready, bus.arready, ipi_m} !== 5'd0) begin bad++;
         $display("FAIL midrst: got %b want 0", {bus.bvalid, bus.awready, bus.arready, ipi_m}); end
      @(negedge aclk);
      areset = 1'b0;
      bus.bready = 1'b1;
      repeat (3) @(negedge aclk);
      total++; if ({bus.bvalid, ipi_m, bus.awready} !== 4'b0001) begin bad++;
         $display("FAIL midrst_after: got %b want 0001", {bus.bvalid, ipi_m, bus.awready}); end
      axi_read(32'h0200_4000, d, r, lat);
      total++; if (d !== 32'hFFFF_FFFF) begin bad++;
         $display("FAIL midrst_cmp: got %h want ffffffff", d); end
   endtask

   initial begin
      areset = 1'b1;
      bus.awaddr = 32'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0; bus.wlast = 1'b0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = 32'd0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      bus4.awaddr = 32'd0; bus4.awvalid = 1'b0; bus4.wdata = 32'd0; bus4.wlast = 1'b0;
      bus4.wvalid = 1'b0; bus4.bready = 1'b0; bus4.araddr = 32'd0; bus4.arvalid = 1'b0;
      bus4.rready = 1'b0;
      test_reset();
      test_msip_ssip();
      test_w_before_aw();
      test_timer();
      test_mtime_wrap();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
